// File: rtl/bool_reduce_ctrl.sv
// bool_reduce_ctrl
//   Serial reduction controller. Operand buses are streamed one per
//   valid/ready handshake and folded through one shared 2-input bus
//   combiner (AND / OR / XOR). The NAND, NOR and XNOR variants invert the
//   final value. The result is presented on a valid/ready output port.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      command strobe, sampled only while idle
//   op         000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR
//   nb_ins     operand count for the command (2..MAX_INS)
//   in_valid   operand valid
//   in_ready   operand accept (high for the whole accumulate phase)
//   in_bus     operand data
//   out_valid  result valid
//   out_ready  result consumer ready
//   out_bus    result data; keeps the last result until the next one loads
//   busy       controller is not idle
//   err        one-cycle pulse when a command is rejected
module bool_reduce_ctrl #(
  parameter int BUS_WIDTH = 8,
  parameter int MAX_INS   = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [CNT_WIDTH-1:0] nb_ins,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_bus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_bus,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  state_t               state;
  logic [2:0]           op_q;
  logic [CNT_WIDTH-1:0] nb_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic [BUS_WIDTH-1:0] acc;
  logic [BUS_WIDTH-1:0] acc_next;
  logic                 last_operand;

  // Base 2-input function shared by a variant and its inverted twin.
  function automatic logic [BUS_WIDTH-1:0] combine(
    input logic [2:0]           f,
    input logic [BUS_WIDTH-1:0] a,
    input logic [BUS_WIDTH-1:0] b
  );
    case (f)
      OP_AND, OP_NAND: combine = a & b;
      OP_OR,  OP_NOR:  combine = a | b;
      default:         combine = a ^ b;
    endcase
  endfunction

  function automatic logic inverted(input logic [2:0] f);
    inverted = (f == OP_NAND) || (f == OP_NOR) || (f == OP_XNOR);
  endfunction

  function automatic logic cmd_legal(
    input logic [2:0]           f,
    input logic [CNT_WIDTH-1:0] n
  );
    cmd_legal = (f <= OP_XNOR) && (n >= CNT_WIDTH'(2)) &&
                (n <= CNT_WIDTH'(MAX_INS));
  endfunction

  // First operand seeds the accumulator; later ones fold into it.
  assign acc_next     = (cnt == '0) ? in_bus : combine(op_q, acc, in_bus);
  assign last_operand = (cnt == nb_q - CNT_WIDTH'(1));

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      nb_q      <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_bus   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cmd_legal(op, nb_ins)) begin
              op_q  <= op;
              nb_q  <= nb_ins;
              cnt   <= '0;
              state <= ACCUM;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt + CNT_WIDTH'(1);
            if (last_operand) begin
              out_bus   <= inverted(op_q) ? ~acc_next : acc_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bool_reduce_ctrl.sv
module tb_bool_reduce_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] nb_ins;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_bus;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_bus;
  logic       busy;
  logic       err;

  int tests_run;
  int tests_failed;

  bool_reduce_ctrl #(.BUS_WIDTH(8), .MAX_INS(8), .CNT_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .nb_ins   (nb_ins),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bus   (in_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bus  (out_bus),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] o, input logic [3:0] n);
    start  = 1'b1;
    op     = o;
    nb_ins = n;
    tick();
    start  = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_bus   = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = 3'd0;
    nb_ins    = 4'd0;
    in_valid  = 1'b0;
    in_bus    = 8'h00;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_bus", 32'(out_bus), 32'h00);
    rst_n = 1'b1;
    tick();

    // NOR of 01,02,04 back-to-back
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_bus    = 8'h01;
    cmd(3'd4, 4'd3);
    check("nor_busy", 32'(busy), 32'd1);
    check("nor_in_ready", 32'(in_ready), 32'd1);
    check("nor_no_early_valid", 32'(out_valid), 32'd0);
    tick();
    in_bus = 8'h02;
    tick();
    in_bus = 8'h04;
    tick();
    in_valid = 1'b0;
    check("nor_out_valid", 32'(out_valid), 32'd1);
    check("nor_out_bus", 32'(out_bus), 32'hF8);
    check("nor_in_ready_done", 32'(in_ready), 32'd0);
    tick();
    check("nor_busy_fall", 32'(busy), 32'd0);
    check("nor_valid_fall", 32'(out_valid), 32'd0);
    check("nor_out_bus_retained", 32'(out_bus), 32'hF8);

    // NAND over MAX_INS operands
    cmd(3'd3, 4'd8);
    for (int i = 0; i < 7; i++) send(8'hFF);
    check("nand_not_yet", 32'(out_valid), 32'd0);
    send(8'h7F);
    check("nand_out_valid", 32'(out_valid), 32'd1);
    check("nand_out_bus", 32'(out_bus), 32'h80);
    tick();
    check("nand_idle", 32'(busy), 32'd0);

    // XNOR of AA,0F
    cmd(3'd5, 4'd2);
    send(8'hAA);
    send(8'h0F);
    check("xnor_out_valid", 32'(out_valid), 32'd1);
    check("xnor_out_bus", 32'(out_bus), 32'h5A);
    tick();

    // Illegal commands: bad op, too few, too many
    in_valid = 1'b1;
    cmd(3'd7, 4'd3);
    check("ill_op_err", 32'(err), 32'd1);
    check("ill_op_busy", 32'(busy), 32'd0);
    check("ill_op_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("ill_op_err_clear", 32'(err), 32'd0);
    cmd(3'd0, 4'd1);
    check("ill_nb1_err", 32'(err), 32'd1);
    check("ill_nb1_busy", 32'(busy), 32'd0);
    tick();
    check("ill_nb1_err_clear", 32'(err), 32'd0);
    cmd(3'd0, 4'd9);
    check("ill_nb9_err", 32'(err), 32'd1);
    check("ill_nb9_busy", 32'(busy), 32'd0);
    check("ill_nb9_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("ill_nb9_err_clear", 32'(err), 32'd0);
    check("ill_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    // Backpressure with start pulsed during DONE
    out_ready = 1'b0;
    cmd(3'd1, 4'd2);
    send(8'h10);
    send(8'h01);
    for (int i = 0; i < 4; i++) begin
      start  = (i == 1);
      op     = 3'd0;
      nb_ins = 4'd2;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_bus", 32'(out_bus), 32'h11);
      check("bp_err", 32'(err), 32'd0);
      tick();
    end
    start = 1'b0;
    check("bp_err_after_start", 32'(err), 32'd0);
    check("bp_still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_valid_fall", 32'(out_valid), 32'd0);
    check("bp_idle", 32'(busy), 32'd0);
    tick();
    check("bp_single_result", 32'(out_valid), 32'd0);
    check("bp_no_new_cmd", 32'(busy), 32'd0);

    // XOR with stalls between operands
    cmd(3'd2, 4'd3);
    send(8'h3C);
    tick();
    tick();
    check("stall_in_ready", 32'(in_ready), 32'd1);
    send(8'hFF);
    tick();
    tick();
    check("stall_no_valid", 32'(out_valid), 32'd0);
    send(8'h0F);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_out_bus", 32'(out_bus), 32'hCC);
    tick();

    // Reset mid-ACCUM, asserted between edges
    cmd(3'd0, 4'd3);
    send(8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_bus", 32'(out_bus), 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Fresh AND after reset
    cmd(3'd0, 4'd2);
    send(8'hF0);
    check("and_no_early", 32'(out_valid), 32'd0);
    send(8'h3C);
    check("and_out_valid", 32'(out_valid), 32'd1);
    check("and_out_bus", 32'(out_bus), 32'h30);
    tick();
    check("and_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
